// File: rtl/mmio_pkg.sv
// Shared register map for the MMIO sensor port: word offsets, STATUS bit
// positions, the THRESH reset value and a STATUS word packing helper.
package mmio_pkg;

    typedef enum logic [1:0] {
        REG_STATUS = 2'd0,
        REG_DATA   = 2'd1,
        REG_CTRL   = 2'd2,
        REG_THRESH = 2'd3
    } reg_off_e;

    localparam int ST_EMPTY_BIT = 8;
    localparam int ST_FULL_BIT  = 9;
    localparam int ST_OVF_BIT   = 10;
    localparam int ST_ALARM_BIT = 11;

    localparam logic [15:0] THRESH_RST = 16'h7FFF;

    function automatic logic [31:0] status_word(input logic [7:0] cnt,
                                                input logic empty,
                                                input logic full,
                                                input logic ovf,
                                                input logic alrm);
        logic [31:0] w;
        w = {24'h0, cnt};
        w[ST_EMPTY_BIT] = empty;
        w[ST_FULL_BIT]  = full;
        w[ST_OVF_BIT]   = ovf;
        w[ST_ALARM_BIT] = alrm;
        return w;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Sample FIFO: power-of-two storage with wrapping pointers and an occupancy
// count. The caller guarantees pop only when non-empty and push only when
// not full or when a pop frees a slot in the same cycle. Clear beats push.
module sample_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_din,
    output logic [W-1:0]               o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty,
    output logic                       o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    // Pointers wrap naturally at AW bits; count moves only on push xor pop.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            if (i_push && !i_pop)      r_count <= r_count + 1'b1;
            else if (!i_push && i_pop) r_count <= r_count - 1'b1;
        end
    end

    // Storage needs no reset; the count decides what is valid.
    always_ff @(posedge i_clock) begin
        if (i_push && !i_clear) r_mem[r_wptr] <= i_din;
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/mmio_sensor_port.sv
// MMIO sensor port: a four-register window at BASE_ADDR in front of a sample
// FIFO, with sticky overflow and over-threshold alarm flags.
// Optional macro SENSOR_AVG_EN: push the 4-sample running mean instead of
// the raw sample.
module mmio_sensor_port
    import mmio_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter logic [11:0] BASE_ADDR = 12'hF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic        wren,
    input  logic        rden,
    input  logic [31:0] data,
    output logic [31:0] q_mmio,
    output logic        mmio_hit,
    input  logic        sensor_valid,
    input  logic [15:0] sensor_data,
    output logic        sensor_ready,
    output logic        alarm
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [11:0]   w_addr;
    logic [11:0]   w_diff;
    logic          w_hit;
    reg_off_e      w_off;
    logic          w_wr_ctrl;
    logic          w_wr_thresh;
    logic          w_clear;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [15:0]   w_pval;
    logic [15:0]   w_head;
    logic [CW-1:0] w_count;
    logic          w_empty;
    logic          w_full;
    logic [31:0]   w_rdata;
    logic          w_unused;

    logic          r_enable;
    logic [15:0]   r_thresh;
    logic          r_ovf;
    logic          r_alarm;
    logic [31:0]   r_q;
    logic          r_hit;

    assign w_addr      = address_dmem[11:0];
    assign w_diff      = w_addr - BASE_ADDR;
    assign w_hit       = (w_addr >= BASE_ADDR) &&
                         ({1'b0, w_addr} <= ({1'b0, BASE_ADDR} + 13'd3));
    assign w_off       = reg_off_e'(w_diff[1:0]);
    assign w_wr_ctrl   = wren && w_hit && (w_off == REG_CTRL);
    assign w_wr_thresh = wren && w_hit && (w_off == REG_THRESH);
    assign w_clear     = w_wr_ctrl && data[1];
    assign w_pop       = rden && w_hit && (w_off == REG_DATA) && !w_empty;
    // A sample arriving while full is still taken when a pop frees the slot
    // in the same cycle; otherwise it is dropped and flagged.
    assign w_push      = sensor_valid && r_enable && (!w_full || w_pop) && !w_clear;
    assign w_drop      = sensor_valid && r_enable && w_full && !w_pop;
    assign w_unused    = ^{address_dmem[31:12], data[31:16], w_diff[11:2]};

`ifdef SENSOR_AVG_EN
    logic [15:0] r_win0, r_win1, r_win2;
    logic [17:0] w_sum;

    assign w_sum  = {{2{sensor_data[15]}}, sensor_data} + {{2{r_win0[15]}}, r_win0}
                  + {{2{r_win1[15]}}, r_win1} + {{2{r_win2[15]}}, r_win2};
    assign w_pval = w_sum[17:2];

    // Window of the three previous accepted samples, zero-filled after clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_win0 <= '0;
            r_win1 <= '0;
            r_win2 <= '0;
        end else if (w_clear) begin
            r_win0 <= '0;
            r_win1 <= '0;
            r_win2 <= '0;
        end else if (w_push) begin
            r_win0 <= sensor_data;
            r_win1 <= r_win0;
            r_win2 <= r_win1;
        end
    end
`else
    assign w_pval = sensor_data;
`endif

    sample_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
        .i_clock (clock),
        .i_reset (reset),
        .i_clear (w_clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_pval),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Read mux; an empty DATA load returns zero.
    always_comb begin
        w_rdata = '0;
        case (w_off)
            REG_STATUS: w_rdata = status_word(8'(w_count), w_empty, w_full, r_ovf, r_alarm);
            REG_DATA:   w_rdata = w_empty ? 32'h0 : {{16{w_head[15]}}, w_head};
            REG_CTRL:   w_rdata = {31'h0, r_enable};
            REG_THRESH: w_rdata = {16'h0, r_thresh};
            default:    w_rdata = '0;
        endcase
    end

    // Control registers and sticky flags; clear beats any set in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_enable <= 1'b0;
            r_thresh <= THRESH_RST;
            r_ovf    <= 1'b0;
            r_alarm  <= 1'b0;
        end else begin
            if (w_wr_ctrl)   r_enable <= data[0];
            if (w_wr_thresh) r_thresh <= data[15:0];
            if (w_clear) begin
                r_ovf   <= 1'b0;
                r_alarm <= 1'b0;
            end else begin
                if (w_drop) r_ovf <= 1'b1;
                if (w_push && ($signed(w_pval) > $signed(r_thresh))) r_alarm <= 1'b1;
            end
        end
    end

    // One-cycle registered load response.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q   <= '0;
            r_hit <= 1'b0;
        end else begin
            r_hit <= rden && w_hit;
            r_q   <= (rden && w_hit) ? w_rdata : 32'h0;
        end
    end

    assign q_mmio       = r_q;
    assign mmio_hit     = r_hit;
    assign sensor_ready = r_enable && !w_full;
    assign alarm        = r_alarm;

endmodule

// File: doc/mmio_sensor_port.md
MMIO_SENSOR_PORT -- requirements
Module: mmio_sensor_port

Interface
REQ-001 Parameter DEPTH, default 8, sets FIFO entries; SHALL be a power of two from 2 to 64.
REQ-002 Parameter BASE_ADDR, default 12'hF00, sets the 12-bit word address of register 0.
REQ-003 Port clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port address_dmem, input, 32 bits: processor data address; only bits [11:0] SHALL be decoded.
REQ-006 Port wren, input, 1 bit: processor store strobe.
REQ-007 Port rden, input, 1 bit: processor load strobe, one-cycle pulse per load.
REQ-008 Port data, input, 32 bits: store data.
REQ-009 Port q_mmio, output, 32 bits: registered read data.
REQ-010 Port mmio_hit, output, 1 bit: registered flag marking q_mmio as valid for the previous cycle's address; wrapper muxes it against the RAM output.
REQ-011 Port sensor_valid, input, 1 bit: sensor sample valid.
REQ-012 Port sensor_data, input, 16 bits: signed temperature code.
REQ-013 Port sensor_ready, output, 1 bit: block accepts a sample.
REQ-014 Port alarm, output, 1 bit: registered over-threshold flag.

Function
REQ-015 Register map (word offset from BASE_ADDR), SHALL be:
- 0 STATUS (RO): [7:0] count, [8] empty, [9] full, [10] overflow, [11] alarm.
- 1 DATA (RO, pop): head sample, sign-extended to 32 bits.
- 2 CTRL (RW): [0] enable, [1] clear (self-clearing, write-1).
- 3 THRESH (RW): [15:0] signed alarm threshold.
REQ-016 Addresses outside BASE_ADDR..BASE_ADDR+3 SHALL leave mmio_hit low and SHALL cause no state change.
REQ-017 Load latency SHALL be one cycle: rden at cycle N gives q_mmio/mmio_hit at cycle N+1.
REQ-018 A DATA load SHALL return the head and pop it; a DATA load when empty SHALL return 0 and SHALL not pop.
REQ-019 sensor_ready SHALL equal enable AND NOT full; a sample SHALL be pushed when sensor_valid AND sensor_ready are both high.
REQ-020 When sensor_valid is high while enable=1 and the FIFO is full, the block SHALL drop the sample and set overflow (sticky until clear).
REQ-021 Push and pop in the same cycle SHALL leave count unchanged, and SHALL be legal when full or when count is 1.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; count SHALL saturate at DEPTH.
REQ-023 alarm SHALL be set the cycle after a pushed sample is signed-greater than THRESH, and SHALL be cleared by clear.
REQ-024 clear SHALL empty the FIFO and reset overflow and alarm; if a push coincides with clear, clear SHALL win.
REQ-025 A store with wren to a read-only register SHALL be ignored.

Reset
REQ-026 While reset is low, the following SHALL hold: pointers=0, count=0, enable=0, THRESH=16'h7FFF, overflow=0, alarm=0, q_mmio=0, mmio_hit=0, sensor_ready=0.
REQ-027 Reset asserted mid-transaction SHALL discard FIFO contents and any pending read.

Configuration
REQ-028 With macro SENSOR_AVG_EN defined, each pushed value SHALL be the arithmetic-shift mean of the last 4 accepted samples, with the window cleared on reset or clear and treated as zero-filled.
REQ-029 Without SENSOR_AVG_EN, raw samples SHALL be pushed unchanged.

Structure
REQ-030 The register offsets, the STATUS bit positions and the THRESH reset value SHALL live in a shared package, mmio_pkg.
REQ-031 FIFO storage and pointers SHALL be a sub-module, sample_fifo.

Verification
REQ-032 Reset, then load STATUS: q_mmio=32'h100 (empty) and sensor_ready=0.
REQ-033 Store CTRL=1, push 3 samples 16'h0010, 16'hFFF0, 16'h0020, then load DATA 3 times: results 0x10, 0xFFFFFFF0, 0x20, and a 4th load returns 0.
REQ-034 With DEPTH=8, push 9 samples: sensor_ready=0 after the 8th, and STATUS=0x608 (full, overflow, count 8).
REQ-035 With the FIFO full, a simultaneous push and DATA pop in the same cycle: count stays 8 and the oldest sample is returned.
REQ-036 Store THRESH=0x0050, push 0x0051: alarm=1 the next cycle; store CTRL=3: alarm=0 and FIFO empty.
REQ-037 With SENSOR_AVG_EN defined, push 4, 8, 12, 16: the popped values are 1, 3, 6, 10.
